dq_release_ctrl: RTL

Commit-side releaser for the dispatch data queues (imm, pc, predicted-taken-pc). Accepts up to COMMIT_WID data-queue indices per cycle from retiring instructions in unordered lanes, compacts them into a circular pending buffer, and drains up to RELEASE_WID per cycle as registered write-back (release) strobes. Those strobes feed the queue's `i_wb_vld`/`i_wb_dqIdx` so that entries become clearable. It decouples commit bursts from the queue's fixed release width.

---
 rtl/dq_release_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dq_release_ctrl.sv
// Commit-side releaser for the dispatch data queues: compacts unordered commit lanes
// into a circular pending buffer and drains them as registered write-back strobes.
module dq_release_ctrl #(
  parameter int DEPTH       = 30,
  parameter int COMMIT_WID  = 4,
  parameter int RELEASE_WID = 4,
  parameter int BUF_DEPTH   = 16,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  o_can_accept,
  input  logic [COMMIT_WID-1:0]                 i_commit_vld,
  input  logic [COMMIT_WID-1:0][IDX_W-1:0]      i_commit_dqIdx,
  output logic [RELEASE_WID-1:0]                o_wb_vld,
  output logic [RELEASE_WID-1:0][IDX_W-1:0]     o_wb_dqIdx,
  output logic [CNT_W-1:0]                      o_count,
  output logic                                  o_overflow
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Wide enough for count + lane count + release count without wrapping.
  localparam int SUM_W = $clog2(BUF_DEPTH + COMMIT_WID + RELEASE_WID + 1) + 1;

  typedef logic [SUM_W-1:0] sum_t;

  // Circular pointer add; both operands are < BUF_DEPTH so one subtraction suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input sum_t base, input sum_t off);
    sum_t s;
    s = base + off;
    if (s >= sum_t'(BUF_DEPTH)) s = s - sum_t'(BUF_DEPTH);
    return PTR_W'(s);
  endfunction

  function automatic sum_t min_sum(input sum_t a, input sum_t b);
    return (a < b) ? a : b;
  endfunction

  logic [IDX_W-1:0]                 pend_buf [BUF_DEPTH];
  logic [PTR_W-1:0]                 head;
  logic [PTR_W-1:0]                 tail;
  logic [CNT_W-1:0]                 count;
  logic                             overflow;
  logic [RELEASE_WID-1:0]           wb_vld_p1;
  logic [RELEASE_WID-1:0][IDX_W-1:0] wb_idx_p1;

  logic                             any_commit;
  logic                             can_accept;
  logic                             acc;
  sum_t                             commit_cnt;
  sum_t                             lane_off [COMMIT_WID];
  logic [PTR_W-1:0]                 wr_ptr   [COMMIT_WID];
  logic [PTR_W-1:0]                 rd_ptr   [RELEASE_WID];
  sum_t                             enq;
  sum_t                             drn;

  // ---- p0: accept decision and lane compaction (combinational on registered state) ----
  assign any_commit = |i_commit_vld;
  assign can_accept = (sum_t'(count) + sum_t'(COMMIT_WID)) <= sum_t'(BUF_DEPTH);
  assign acc        = any_commit & can_accept;

  always_comb begin
    commit_cnt = '0;
    for (int j = 0; j < COMMIT_WID; j++) begin
      lane_off[j] = commit_cnt;
      if (i_commit_vld[j]) commit_cnt = commit_cnt + sum_t'(1);
    end
  end

  always_comb begin
    for (int j = 0; j < COMMIT_WID; j++) begin
      wr_ptr[j] = wrap_add(sum_t'(tail), lane_off[j]);
    end
  end

  always_comb begin
    for (int k = 0; k < RELEASE_WID; k++) begin
      rd_ptr[k] = wrap_add(sum_t'(head), sum_t'(k));
    end
  end

  // Drain is based on the start-of-cycle count, so same-cycle enqueues never leave early.
  assign enq = acc ? commit_cnt : '0;
  assign drn = min_sum(sum_t'(count), sum_t'(RELEASE_WID));

  // ---- p0 -> p1: buffer write (data path, no reset) ----
  always_ff @(posedge clk) begin
    for (int j = 0; j < COMMIT_WID; j++) begin
      if (acc && i_commit_vld[j]) pend_buf[wr_ptr[j]] <= i_commit_dqIdx[j];
    end
  end

  // ---- p0 -> p1: pointers, count, overflow and registered release strobes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      wb_vld_p1 <= '0;
      wb_idx_p1 <= '0;
    end else begin
      head     <= wrap_add(sum_t'(head), drn);
      tail     <= wrap_add(sum_t'(tail), enq);
      count    <= CNT_W'(sum_t'(count) + enq - drn);
      overflow <= overflow | (any_commit & ~can_accept);
      for (int k = 0; k < RELEASE_WID; k++) begin
        if (sum_t'(k) < drn) begin
          wb_vld_p1[k] <= 1'b1;
          wb_idx_p1[k] <= pend_buf[rd_ptr[k]];
        end else begin
          wb_vld_p1[k] <= 1'b0;
          wb_idx_p1[k] <= '0;
        end
      end
    end
  end

  // ---- p1: outputs ----
  assign o_can_accept = can_accept;
  assign o_count      = count;
  assign o_overflow   = overflow;
  assign o_wb_vld     = wb_vld_p1;
  assign o_wb_dqIdx   = wb_idx_p1;

endmodule
